// File: rtl/key_expand_iter.sv
// key_expand_iter -- iterative AES key-schedule engine (AES-128/192/256).
//
// Produces one 32-bit schedule word per clock into an internal round-key
// store. Once the schedule is complete it serves round keys through a
// registered indexed read port. Only four S-boxes are used, shared by both
// substitution cases of the schedule.
//
// Parameters:
//   KEY_BITS   128, 192 or 256. Nk = KEY_BITS/32, Nr = Nk+6, NW = 4*(Nr+1).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (the word store is not cleared)
//   zeroize    (only with KEY_EXPAND_ZEROIZE_EN) clears the store and all state
//   start      begin expansion of key (sampled only in IDLE)
//   key        cipher key, bits KEY_BITS-1:KEY_BITS-32 are w[0]
//   busy       high while expanding
//   done       one-cycle pulse after the last word is written
//   key_valid  store holds a complete schedule
//   rd_idx     round-key index 0..Nr
//   rd_key     round key rd_idx (1-cycle latency), 0 if invalid or out of range
//
// Optional feature macro: KEY_EXPAND_ZEROIZE_EN
module key_expand_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
`ifdef KEY_EXPAND_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                done,
    output logic                key_valid,
    input  logic [3:0]          rd_idx,
    output logic [127:0]        rd_key
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK6     = 6'(NK);
    localparam logic [5:0] NW_LAST = 6'(NW - 1);
    localparam logic [2:0] J_LAST  = 3'(NK - 1);
    localparam logic [3:0] NR4     = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("key_expand_iter: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    // GF(2^8) helpers; the S-box is built as inverse (x^254) plus affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        r = x;
        // r -> x^3, x^7, ... x^127, then one more square gives x^254 = x^-1.
        for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
        b = gf_mul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t         state_q, state_d;
    logic [5:0]     i_q, i_d;
    logic [2:0]     j_q, j_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           key_valid_q, key_valid_d;
    logic           done_q, done_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic [31:0]    w_q [NW];
    logic [31:0]    w_d [NW];

    logic [31:0]    prev_w, back_w, sub_in, sub_out, t;
    logic           clr;
    logic           store_en;
    logic [5:0]     rd_base;

`ifdef KEY_EXPAND_ZEROIZE_EN
    assign clr = zeroize;
`else
    assign clr = 1'b0;
`endif
    // The store is frozen while reset is low unless it is being zeroized.
    assign store_en = reset | clr;

    assign prev_w = w_q[i_q - 6'd1];
    assign back_w = w_q[i_q - NK6];
    // Rotation only applies on the first word of each Nk-word group.
    assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
        end
    endgenerate

    assign rd_base = {rd_idx, 2'b00};

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        w_d         = w_q;
        t           = prev_w;

        if (j_q == 3'd0) begin
            t = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && j_q == 3'd4) begin
            t = sub_out;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NK; k++) begin
                        w_d[k] = key[KEY_BITS-1-32*k -: 32];
                    end
                    i_d         = NK6;
                    j_d         = 3'd0;
                    rcon_d      = 8'h01;
                    key_valid_d = 1'b0;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                w_d[i_q] = back_w ^ t;
                if (j_q == 3'd0) rcon_d = xtime(rcon_q);
                i_d = i_q + 6'd1;
                j_d = (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
                if (i_q == NW_LAST) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d     = IDLE;
            i_d         = 6'd0;
            j_d         = 3'd0;
            rcon_d      = 8'h00;
            key_valid_d = 1'b0;
            done_d      = 1'b0;
            for (int k = 0; k < NW; k++) w_d[k] = 32'h0;
        end

        // Read is gated by the registered key_valid, so a change in validity
        // shows on rd_key one edge later.
        rd_key_d = 128'h0;
        if (key_valid_q && !clr && rd_idx <= NR4) begin
            rd_key_d = {w_q[rd_base], w_q[rd_base + 6'd1],
                        w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            i_q         <= 6'd0;
            j_q         <= 3'd0;
            rcon_q      <= 8'h00;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rd_key_q    <= 128'h0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
            rd_key_q    <= rd_key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) w_q <= w_d;
    end

    assign busy      = (state_q == EXPAND);
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_expand_iter.sv
// Testbench for key_expand_iter: three instances (AES-128/192/256) driven
// with FIPS-197 directed vectors. Stimulus pushes expected read data and
// expected done cycles into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_key_expand_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        reset_v;
    logic [2:0]        start_v;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0]        kv_v;
    logic [2:0]        zero_v;
    logic [2:0][3:0]   rd_idx_v;
    logic [2:0][127:0] rd_key_v;
    logic [127:0]      key128;
    logic [191:0]      key192;
    logic [255:0]      key256;

    key_expand_iter #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .reset(reset_v[0]),
`ifdef KEY_EXPAND_ZEROIZE_EN
        .zeroize(zero_v[0]),
`endif
        .start(start_v[0]), .key(key128), .busy(busy_v[0]), .done(done_v[0]),
        .key_valid(kv_v[0]), .rd_idx(rd_idx_v[0]), .rd_key(rd_key_v[0])
    );
    key_expand_iter #(.KEY_BITS(192)) u_aes192 (
        .clk(clk), .reset(reset_v[1]),
`ifdef KEY_EXPAND_ZEROIZE_EN
        .zeroize(zero_v[1]),
`endif
        .start(start_v[1]), .key(key192), .busy(busy_v[1]), .done(done_v[1]),
        .key_valid(kv_v[1]), .rd_idx(rd_idx_v[1]), .rd_key(rd_key_v[1])
    );
    key_expand_iter #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .reset(reset_v[2]),
`ifdef KEY_EXPAND_ZEROIZE_EN
        .zeroize(zero_v[2]),
`endif
        .start(start_v[2]), .key(key256), .busy(busy_v[2]), .done(done_v[2]),
        .key_valid(kv_v[2]), .rd_idx(rd_idx_v[2]), .rd_key(rd_key_v[2])
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rd_req = 1'b0;
    int   rd_sel = 0;
    logic rsp_pend = 1'b0;
    int   rsp_sel = 0;

    string        rd_name_q[$];
    logic [127:0] rd_exp_q[$];
    int           done_sel_q[$];
    int           done_stamp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    // Cycle stamp and read-response tracking, advanced on the active edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rsp_pend <= rd_req;
        rsp_sel  <= rd_sel;
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        if (rsp_pend) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected dut%0d got %h want no response", rsp_sel, rd_key_v[rsp_sel]);
            end else begin
                string        nm;
                logic [127:0] ex;
                nm = rd_name_q.pop_front();
                ex = rd_exp_q.pop_front();
                chk(nm, rd_key_v[rsp_sel], ex);
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (done_v[d] === 1'b1) begin
                checks++;
                if (done_sel_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected dut%0d got done at cycle %0d want no done", d, cyc);
                end else begin
                    int s;
                    int st;
                    s  = done_sel_q.pop_front();
                    st = done_stamp_q.pop_front();
                    if (s != d || st != cyc) begin
                        errors++;
                        $display("FAIL done_timing got dut%0d cycle %0d want dut%0d cycle %0d", d, cyc, s, st);
                    end else begin
                        $display("ok   done_timing dut%0d cycle %0d", d, cyc);
                    end
                end
            end
        end
    end

    task automatic do_start(input int d, input bit exp_done, input int hold);
        int lat;
        lat = (d == 0) ? 40 : (d == 1) ? 46 : 52;
        start_v[d] = 1'b1;
        if (exp_done) begin
            done_sel_q.push_back(d);
            done_stamp_q.push_back(cyc + 1 + lat);
        end
        @(negedge clk);
        repeat (hold) @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (done_v[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_wait dut%0d got no done want done within 200 cycles", d);
        end else begin
            chk($sformatf("busy_at_done_dut%0d", d), busy_v[d], 1'b0);
            chk($sformatf("key_valid_at_done_dut%0d", d), kv_v[d], 1'b1);
        end
    endtask

    task automatic do_read(input int d, input logic [3:0] idx, input logic [127:0] exp, input string nm);
        rd_idx_v[d] = idx;
        rd_sel      = d;
        rd_req      = 1'b1;
        rd_name_q.push_back(nm);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_v  = 3'b000;
        start_v  = 3'b000;
        zero_v   = 3'b000;
        rd_idx_v = '0;
        key128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_busy_dut%0d", d), busy_v[d], 1'b0);
            chk($sformatf("reset_done_dut%0d", d), done_v[d], 1'b0);
            chk($sformatf("reset_key_valid_dut%0d", d), kv_v[d], 1'b0);
            chk($sformatf("reset_rd_key_dut%0d", d), rd_key_v[d], 128'h0);
        end
        reset_v = 3'b111;
        @(negedge clk);

        // AES-128 basic run, with a read issued while expanding.
        do_start(0, 1'b1, 0);
        chk("aes128_busy_after_start", busy_v[0], 1'b1);
        do_read(0, 4'd0, 128'h0, "aes128_read_during_expand");
        wait_done(0);
        do_read(0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_rk0");
        do_read(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_rk1");
        do_read(0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "aes128_rk2");
        do_read(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10");
        do_read(0, 4'd11, 128'h0, "aes128_rk11_out_of_range");

        // AES-192 back-to-back: second start issued in the done cycle.
        do_start(1, 1'b1, 0);
        wait_done(1);
        do_start(1, 1'b1, 0);
        chk("aes192_restart_busy", busy_v[1], 1'b1);
        wait_done(1);
        do_read(1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "aes192_rk0");
        do_read(1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "aes192_rk1");
        do_read(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12");
        do_read(1, 4'd13, 128'h0, "aes192_rk13_out_of_range");

        // AES-256 with start held high during expansion.
        do_start(2, 1'b1, 10);
        wait_done(2);
        do_read(2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "aes256_rk0");
        do_read(2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "aes256_rk1");
        do_read(2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, "aes256_rk2");
        do_read(2, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a, "aes256_rk3");
        do_read(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");
        do_read(2, 4'd15, 128'h0, "aes256_rk15_out_of_range");

        // AES-128 restart over a valid schedule, then reset at cycle 20.
        do_start(0, 1'b0, 0);
        chk("aes128_restart_key_valid", kv_v[0], 1'b0);
        repeat (19) @(negedge clk);
        reset_v[0] = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy_v[0], 1'b0);
        chk("midreset_done", done_v[0], 1'b0);
        chk("midreset_key_valid", kv_v[0], 1'b0);
        chk("midreset_rd_key", rd_key_v[0], 128'h0);
        reset_v[0] = 1'b1;
        @(negedge clk);
        do_start(0, 1'b1, 0);
        wait_done(0);
        do_read(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_after_reset_rk1");
        do_read(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_after_reset_rk10");

`ifdef KEY_EXPAND_ZEROIZE_EN
        do_start(0, 1'b0, 0);
        repeat (9) @(negedge clk);
        zero_v[0] = 1'b1;
        @(negedge clk);
        zero_v[0] = 1'b0;
        chk("zeroize_mid_busy", busy_v[0], 1'b0);
        chk("zeroize_mid_key_valid", kv_v[0], 1'b0);
        repeat (50) @(negedge clk);
        do_start(0, 1'b1, 0);
        wait_done(0);
        zero_v[0] = 1'b1;
        @(negedge clk);
        zero_v[0] = 1'b0;
        chk("zeroize_after_done_key_valid", kv_v[0], 1'b0);
        for (int r = 0; r < 16; r++) begin
            do_read(0, 4'(r), 128'h0, $sformatf("zeroized_rk%0d", r));
        end
        start_v[0] = 1'b1;
        zero_v[0]  = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        zero_v[0]  = 1'b0;
        chk("start_and_zeroize_busy", busy_v[0], 1'b0);
        repeat (60) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("pending_reads_left", 128'(rd_exp_q.size()), 128'h0);
        chk("pending_dones_left", 128'(done_sel_q.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
